// File: rtl/distance_argmin.sv
// distance_argmin
// Streaming reduction stage that sits after the Euclidean distance unit.
// A frame of unsigned fixed-point distances arrives over a valid/ready
// handshake. The stage tracks the smallest distance and the index of the first
// beat holding it. It also counts the beats and the beats closer than a
// per-frame threshold. One result per frame is then offered on an output
// handshake.
//
// Parameters:
//   WIDTH - distance/threshold width (unsigned fixed point)
//   FRAC  - fractional bits (informational; compares are plain unsigned)
//   IDX_W - index width; at most 2^IDX_W beats per frame are counted
//
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset
//   in_valid     - distance beat valid
//   in_ready     - block accepts a beat (low while a result is pending)
//   in_dist      - candidate distance
//   in_last      - final beat of the frame
//   threshold    - near radius, captured on the first beat of a frame
//   out_valid    - result valid
//   out_ready    - downstream accepts the result
//   out_min_dist - smallest counted distance in the frame
//   out_min_idx  - 0-based index of the first beat holding the minimum
//   out_count    - counted beats, saturating at 2^IDX_W
//   out_near_cnt - counted beats with in_dist < threshold
//   out_overflow - frame carried more than 2^IDX_W beats
module distance_argmin #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int IDX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_dist,
  input  logic               in_last,
  input  logic [WIDTH-1:0]   threshold,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_min_dist,
  output logic [IDX_W-1:0]   out_min_idx,
  output logic [IDX_W:0]     out_count,
  output logic [IDX_W:0]     out_near_cnt,
  output logic               out_overflow
);

  // The fractional point position is fixed by the upstream format and must fit.
  if (FRAC > WIDTH) begin : g_frac_check
    $error("distance_argmin: FRAC must not exceed WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Count value at which the frame is full (2^IDX_W).
  localparam logic [IDX_W:0] FULL_CNT = {1'b1, {IDX_W{1'b0}}};

  state_t             state_r;
  logic [WIDTH-1:0]   min_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W:0]     count_r;
  logic [IDX_W:0]     near_r;
  logic [WIDTH-1:0]   thr_r;
  logic               ovf_r;

  logic               beat_s;
  logic               lt_first_s;
  logic               lt_thr_s;
  logic               lt_min_s;
  logic               full_s;
  logic [WIDTH-1:0]   nxt_min_s;
  logic [IDX_W-1:0]   nxt_idx_s;
  logic [IDX_W:0]     nxt_count_s;
  logic [IDX_W:0]     nxt_near_s;
  logic               nxt_ovf_s;

  assign beat_s     = in_valid && in_ready;
  // The first beat compares against the live threshold because thr_r is only
  // loaded by that same beat; later beats use the captured value.
  assign lt_first_s = (in_dist < threshold);
  assign lt_thr_s   = (in_dist < thr_r);
  assign lt_min_s   = (in_dist < min_r);
  assign full_s     = (count_r == FULL_CNT);

  // Accumulator values after the beat presented in this cycle is taken.
  always_comb begin
    nxt_min_s   = min_r;
    nxt_idx_s   = idx_r;
    nxt_count_s = count_r;
    nxt_near_s  = near_r;
    nxt_ovf_s   = ovf_r;
    case (state_r)
      IDLE: begin
        nxt_min_s   = in_dist;
        nxt_idx_s   = {IDX_W{1'b0}};
        nxt_count_s = {{IDX_W{1'b0}}, 1'b1};
        nxt_near_s  = {{IDX_W{1'b0}}, lt_first_s};
        nxt_ovf_s   = 1'b0;
      end
      ACCUM: begin
        if (full_s) begin
          // Beat beyond capacity: consumed but only flags overflow.
          nxt_ovf_s = 1'b1;
        end else begin
          // Strict compare keeps the earliest index on ties.
          if (lt_min_s) begin
            nxt_min_s = in_dist;
            nxt_idx_s = count_r[IDX_W-1:0];
          end else begin
            nxt_min_s = min_r;
            nxt_idx_s = idx_r;
          end
          nxt_count_s = count_r + {{IDX_W{1'b0}}, 1'b1};
          nxt_near_s  = near_r + {{IDX_W{1'b0}}, lt_thr_s};
        end
      end
      default: begin
        nxt_ovf_s = ovf_r;
      end
    endcase
  end

  // Frame FSM with accumulators, handshake flags and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      min_r        <= {WIDTH{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      count_r      <= {(IDX_W+1){1'b0}};
      near_r       <= {(IDX_W+1){1'b0}};
      thr_r        <= {WIDTH{1'b0}};
      ovf_r        <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_min_dist <= {WIDTH{1'b0}};
      out_min_idx  <= {IDX_W{1'b0}};
      out_count    <= {(IDX_W+1){1'b0}};
      out_near_cnt <= {(IDX_W+1){1'b0}};
      out_overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (beat_s) begin
            min_r   <= nxt_min_s;
            idx_r   <= nxt_idx_s;
            count_r <= nxt_count_s;
            near_r  <= nxt_near_s;
            ovf_r   <= nxt_ovf_s;
            if (state_r == IDLE) begin
              thr_r <= threshold;
            end
            if (in_last) begin
              // Publish the post-beat values so the last beat is included.
              out_min_dist <= nxt_min_s;
              out_min_idx  <= nxt_idx_s;
              out_count    <= nxt_count_s;
              out_near_cnt <= nxt_near_s;
              out_overflow <= nxt_ovf_s;
              out_valid    <= 1'b1;
              in_ready     <= 1'b0;
              state_r      <= HOLD;
            end else begin
              state_r <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
